cga_alu_dbr_queue: RTL

Parametrised data bus register queue for the CGA ALU. It is the next generation of the single-entry DBR: a `WIDTH`-bit, `DEPTH`-entry first-in-first-out buffer loaded from the CD bus, with optional byte swap on load, a synchronous flush, and sticky overflow/underflow flags. The head entry drives the ALU-side DBR output, so the microcode can post several CD-bus words before the ALU consumes them.

---
 rtl/cga_alu_dbr_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cga_alu_dbr_queue.sv
// -----------------------------------------------------------------------------
// cga_alu_dbr_queue
//   Data bus register queue for the CGA ALU. This is a WIDTH x DEPTH FIFO that
//   is loaded from the CD bus. A word can be byte-swapped as it is stored.
//   The queue has a synchronous flush and two sticky error flags, one for
//   overflow and one for underflow. The head entry drives the ALU-side DBR
//   output.
//
// Ports
//   ALUCLK     in   clock; all state changes on the rising edge
//   RESETN     in   synchronous active-low reset
//   CD_15_0    in   CD bus data to load
//   LDDBRN     in   active-low push request
//   RDDBRN     in   active-low pop request
//   SWAPB      in   exchange the two bytes on store
//   FLUSHN     in   active-low synchronous flush (also clears flags)
//   CLRFLGN    in   active-low synchronous clear of the sticky flags
//   DBR_15_0   out  head entry, zero when empty
//   DBR_EMPTY  out  occupancy == 0
//   DBR_FULL   out  occupancy == DEPTH
//   DBR_CNT    out  occupancy 0..DEPTH
//   DBR_OVF    out  sticky: a push was dropped
//   DBR_UNF    out  sticky: a pop was issued on an empty queue
// -----------------------------------------------------------------------------
module cga_alu_dbr_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             ALUCLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] CD_15_0,
    input  logic             LDDBRN,
    input  logic             RDDBRN,
    input  logic             SWAPB,
    input  logic             FLUSHN,
    input  logic             CLRFLGN,
    output logic [WIDTH-1:0] DBR_15_0,
    output logic             DBR_EMPTY,
    output logic             DBR_FULL,
    output logic [CW-1:0]    DBR_CNT,
    output logic             DBR_OVF,
    output logic             DBR_UNF
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             empty, full;
    logic             push, pop;
    logic             ovf_set, unf_set;
    logic [WIDTH-1:0] wdata;

    // The status outputs are decoded from the count register only, so they
    // never depend combinationally on the request inputs.
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

    // A pop is accepted only when the queue holds data. A push is accepted
    // when there is room, or when a pop in the same cycle frees the head slot.
    // There is no empty-queue bypass: a push and a pop on an empty queue
    // store the word and flag an underflow.
    assign pop     = ~RDDBRN & ~empty;
    assign push    = ~LDDBRN & (~full | pop);
    assign ovf_set = ~LDDBRN & full & ~pop;
    assign unf_set = ~RDDBRN & empty;

    assign wdata = SWAPB ? {CD_15_0[WIDTH/2-1:0], CD_15_0[WIDTH-1:WIDTH/2]}
                         : CD_15_0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
        // When a set and a clear happen in the same cycle, the set wins.
        ovf_d = (ovf_q & CLRFLGN) | ovf_set;
        unf_d = (unf_q & CLRFLGN) | unf_set;
    end

    always_ff @(posedge ALUCLK) begin
        if (!RESETN || !FLUSHN) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // The storage array has no reset. Its contents are hidden behind the
    // zero-gated output until they are written.
    always_ff @(posedge ALUCLK) begin
        if (RESETN && FLUSHN && push)
            mem_q[wr_ptr_q] <= wdata;
    end

    assign DBR_15_0  = empty ? '0 : mem_q[rd_ptr_q];
    assign DBR_EMPTY = empty;
    assign DBR_FULL  = full;
    assign DBR_CNT   = cnt_q;
    assign DBR_OVF   = ovf_q;
    assign DBR_UNF   = unf_q;

endmodule
